// File: rtl/otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : otter_fetch_queue
// Description : OTTER instruction-fetch front end. Owns the fetch PC, issues
//               word reads to a 1-cycle-latency instruction port and buffers
//               returned words with their PCs for decode.
// Revision    : 1.0 - initial release
// ============================================================================
module otter_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     imem_ready,
    output logic                     imem_req,
    output logic [13:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    output logic                     de_valid,
    input  logic                     de_ready,
    output logic [31:0]              de_ir,
    output logic [31:0]              de_pc,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int          c_AW  = $clog2(DEPTH);
    localparam int          c_CW  = c_AW + 1;
    localparam logic [31:0] c_NOP = 32'h0000_0013;
    localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

    // Control state
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_inflight_pc;
    logic            r_inflight;
    logic            r_kill;
    logic [c_CW-1:0] r_count;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW-1:0] r_wr_ptr;

    // Entry storage
    logic [31:0]     r_ir_mem [DEPTH];
    logic [31:0]     r_pc_mem [DEPTH];

    logic            w_head_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_issue;
    logic [c_CW:0]   w_credit;
    logic [31:0]     w_redirect_target;

    assign w_redirect_target = redirect_pc & ~32'h0000_0003;

    // Occupancy the FIFO would have if the outstanding read lands, after
    // this cycle's pop; an issue is allowed only while this leaves a slot.
    assign w_credit = {1'b0, r_count}
                    + {{c_CW{1'b0}}, r_inflight}
                    - {{c_CW{1'b0}}, w_pop};

    assign w_head_valid = (r_count != '0);
    assign de_valid     = w_head_valid & ~redirect_valid;
    assign w_pop        = de_valid & de_ready;

    assign imem_req  = ~RESET & ~redirect_valid & (w_credit < c_DEPTH);
    assign w_issue   = imem_req & imem_ready;
    assign imem_addr = r_fetch_pc[15:2];

    assign w_push = r_inflight & ~r_kill & ~redirect_valid;

    assign de_ir   = de_valid ? r_ir_mem[r_rd_ptr] : c_NOP;
    assign de_pc   = de_valid ? r_pc_mem[r_rd_ptr] : 32'h0000_0000;
    assign q_count = r_count;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fetch_pc    <= RESET_PC;
            r_inflight_pc <= '0;
            r_inflight    <= 1'b0;
            r_kill        <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= redirect_valid & r_inflight;
            if (w_issue) begin
                r_inflight_pc <= r_fetch_pc;
            end

            if (redirect_valid) begin
                r_fetch_pc <= w_redirect_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Payload needs no reset: an entry is only read once count covers it.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_ir_mem[r_wr_ptr] <= imem_rdata;
            r_pc_mem[r_wr_ptr] <= r_inflight_pc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_otter_fetch_queue
// Description : Scoreboard bench for otter_fetch_queue; imem model returns
//               addr*4 as data one cycle after each accepted read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_queue;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_ready = 1'b1;
    logic        imem_req;
    logic [13:0] imem_addr;
    logic [31:0] imem_rdata = 32'hDEAD_BEEF;
    logic        de_valid;
    logic        de_ready = 1'b0;
    logic [31:0] de_ir;
    logic [31:0] de_pc;
    logic [2:0]  q_count;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ir;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   ready_en  = 1'b0;
    bit   toggle_en = 1'b0;

    logic        iss_q = 1'b0;
    logic [13:0] iss_addr = 14'h0;
    logic [13:0] last_addr = 14'h0;
    bit          have_last = 1'b0;

    otter_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK            (clk),
        .RESET          (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_ready     (imem_ready),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .de_valid       (de_valid),
        .de_ready       (de_ready),
        .de_ir          (de_ir),
        .de_pc          (de_pc),
        .q_count        (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ir);
        exp_t e;
        e.pc = pc;
        e.ir = ir;
        exp_q.push_back(e);
    endtask

    task automatic upd();
        de_ready = ready_en && (exp_q.size() != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_en) imem_ready = ~imem_ready;
        upd();
    endtask

    task automatic wait_drain(input int max);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_ready = 1'b1;
        toggle_en = 1'b0;
        ready_en = 1'b0;
        de_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Instruction memory model with issue-address ordering check
    always @(negedge clk) begin
        iss_q    = imem_req & imem_ready;
        iss_addr = imem_addr;
        if (rst || redirect_valid) have_last = 1'b0;
        if (iss_q) begin
            if (have_last)
                check("issue_addr_seq", {18'h0, iss_addr}, {18'h0, last_addr + 14'd1});
            last_addr = iss_addr;
            have_last = 1'b1;
        end
    end

    always @(posedge clk) begin
        imem_rdata <= iss_q ? {16'h0, iss_addr, 2'b00} : 32'hDEAD_BEEF;
    end

    // Decode-side monitor
    always @(negedge clk) begin
        if (de_valid && de_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected_pc", de_pc, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("de_pc", de_pc, mon_e.pc);
                check("de_ir", de_ir, mon_e.ir);
            end
        end else if (!de_valid) begin
            check("idle_ir", de_ir, c_NOP);
            check("idle_pc", de_pc, 32'h0);
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        @(negedge clk);
        check("rst_req",   {31'h0, imem_req}, 32'd0);
        check("rst_addr",  {18'h0, imem_addr}, 32'd0);
        check("rst_valid", {31'h0, de_valid}, 32'd0);
        check("rst_ir",    de_ir, c_NOP);
        check("rst_pc",    de_pc, 32'h0);
        check("rst_count", {29'h0, q_count}, 32'd0);
        tick();
        rst = 1'b0;

        // Streaming: first instruction at cycle 2, then one per cycle
        for (int i = 0; i < 4; i++) push_exp(32'(i * 4), 32'(i * 4));
        ready_en = 1'b1;
        upd();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("stream_valid", {31'h0, de_valid}, (c >= 2) ? 32'd1 : 32'd0);
            tick();
        end
        wait_drain(20);

        // Backpressure: fill to DEPTH, then release in order
        do_reset();
        for (int i = 0; i < 5; i++) push_exp(32'(i * 4), 32'(i * 4));
        upd();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) check("bp_req_credit", {31'h0, imem_req}, 32'd0);
            if (c == 9) begin
                check("bp_count_full", {29'h0, q_count}, 32'd4);
                check("bp_req_full",   {31'h0, imem_req}, 32'd0);
            end
            tick();
        end
        ready_en = 1'b1;
        upd();
        wait_drain(20);

        // Redirect with 3 queued entries and one read in flight
        do_reset();
        repeat (4) tick();
        check("rd_count_pre", {29'h0, q_count}, 32'd3);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        push_exp(32'h100, 32'h100);
        push_exp(32'h104, 32'h104);
        ready_en = 1'b1;
        upd();
        @(negedge clk);
        check("rd_R_valid", {31'h0, de_valid}, 32'd0);
        check("rd_R_req",   {31'h0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("rd_R1_req",   {31'h0, imem_req}, 32'd1);
        check("rd_R1_addr",  {18'h0, imem_addr}, 32'h40);
        check("rd_R1_count", {29'h0, q_count}, 32'd0);
        tick();
        @(negedge clk);
        check("rd_R2_valid", {31'h0, de_valid}, 32'd0);
        tick();
        @(negedge clk);
        check("rd_R3_valid", {31'h0, de_valid}, 32'd1);
        wait_drain(20);

        // Back-to-back redirects: 0x200 must never reach decode
        tick();
        push_exp(32'h300, 32'h300);
        push_exp(32'h304, 32'h304);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        upd();
        tick();
        redirect_pc = 32'h0000_0300;
        @(negedge clk);
        check("b2b_req", {31'h0, imem_req}, 32'd0);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("b2b_addr", {18'h0, imem_addr}, 32'hC0);
        wait_drain(20);

        // imem_ready toggling
        do_reset();
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) push_exp(32'(i * 4), 32'(i * 4));
        ready_en = 1'b1;
        upd();
        wait_drain(60);
        toggle_en = 1'b0;
        imem_ready = 1'b1;

        // Reset mid-stream (count=2, one in flight)
        do_reset();
        repeat (3) tick();
        check("mrst_count_pre", {29'h0, q_count}, 32'd2);
        rst = 1'b1;
        #1;
        check("mrst_req",   {31'h0, imem_req}, 32'd0);
        check("mrst_addr",  {18'h0, imem_addr}, 32'd0);
        check("mrst_valid", {31'h0, de_valid}, 32'd0);
        check("mrst_ir",    de_ir, c_NOP);
        check("mrst_pc",    de_pc, 32'h0);
        check("mrst_count", {29'h0, q_count}, 32'd0);
        tick();
        rst = 1'b0;
        push_exp(32'h0, 32'h0);
        push_exp(32'h4, 32'h4);
        ready_en = 1'b1;
        upd();
        check("mrst_restart_addr", {18'h0, imem_addr}, 32'd0);
        wait_drain(20);

        // Fetch PC wrap from 0xFFFF_FFFC
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        push_exp(32'hFFFF_FFFC, 32'h0000_FFFC);
        push_exp(32'h0000_0000, 32'h0000_0000);
        push_exp(32'h0000_0004, 32'h0000_0004);
        upd();
        tick();
        redirect_valid = 1'b0;
        wait_drain(20);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
